// File: rtl/pic_host_bus_master_if.sv
// Host command/response, interrupt vector and PIC pin bundle for the 8259 bus master.
interface pic_host_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic       cmd_a0;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       int_en;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic       busy;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a0;
  logic       inta_n;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;
  logic       pic_int;

  modport master (
    input  cmd_valid, cmd_write, cmd_a0, cmd_wdata, int_en, d_in, pic_int,
    output cmd_ready, rsp_valid, rsp_rdata, vec_valid, vec_data, busy,
           cs_n, rd_n, wr_n, a0, inta_n, d_out, d_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_a0, cmd_wdata, int_en, d_in, pic_int,
    input  cmd_ready, rsp_valid, rsp_rdata, vec_valid, vec_data, busy,
           cs_n, rd_n, wr_n, a0, inta_n, d_out, d_oe
  );
endinterface

// File: rtl/pic_host_bus_master.sv
// CPU-side initiator for an 8259 PIC: register read/write bus cycles and 8086-mode INTA.
// state | meaning
// IDLE  | waiting; INT has priority over a command
// SETUP | cs_n low, a0/data presented
// STROBE| rd_n or wr_n low
// HOLD  | strobe released, cs_n/a0/data held
// INTA1 | first inta_n pulse
// GAP   | inta_n high between pulses
// INTA2 | second inta_n pulse, vector sampled at its end
// IDONE | vector delivered
module pic_host_bus_master #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pic_host_bus_master_if.master bus
);

  localparam int MAX_CYCLES = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, INTA1, GAP, INTA2, IDONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          int_meta;
  logic          int_s;
  logic          int_armed;
  logic          wr_q;
  logic          inta_start;
  logic          accept;

  assign inta_start    = (state == IDLE) && bus.int_en && int_s && int_armed;
  assign bus.cmd_ready = rst_n && (state == IDLE) && !inta_start;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta <= 1'b0;
      int_s    <= 1'b0;
    end else begin
      int_meta <= bus.pic_int;
      int_s    <= int_meta;
    end
  end

  // Re-arm only after INT is seen low, so a slowly released INT is not acknowledged twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          int_armed <= 1'b1;
    else if (inta_start) int_armed <= 1'b0;
    else if (!int_s)     int_armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      wr_q          <= 1'b0;
      bus.cs_n      <= 1'b1;
      bus.rd_n      <= 1'b1;
      bus.wr_n      <= 1'b1;
      bus.inta_n    <= 1'b1;
      bus.a0        <= 1'b0;
      bus.d_out     <= 8'h00;
      bus.d_oe      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'h00;
      bus.vec_valid <= 1'b0;
      bus.vec_data  <= 8'h00;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.vec_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (inta_start) begin
            state      <= INTA1;
            bus.inta_n <= 1'b0;
            cnt        <= STROBE_LOAD;
          end else if (accept) begin
            state    <= SETUP;
            bus.cs_n <= 1'b0;
            bus.a0   <= bus.cmd_a0;
            wr_q     <= bus.cmd_write;
            bus.d_oe <= bus.cmd_write;
            if (bus.cmd_write) bus.d_out <= bus.cmd_wdata;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= STROBE_LOAD;
          if (wr_q) bus.wr_n <= 1'b0;
          else      bus.rd_n <= 1'b0;
        end
        STROBE: begin
          if (cnt == '0) begin
            state    <= HOLD;
            bus.wr_n <= 1'b1;
            bus.rd_n <= 1'b1;
            if (!wr_q) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= bus.d_in;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state    <= IDLE;
          bus.cs_n <= 1'b1;
          bus.d_oe <= 1'b0;
        end
        INTA1: begin
          if (cnt == '0) begin
            state      <= GAP;
            bus.inta_n <= 1'b1;
            cnt        <= GAP_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state      <= INTA2;
            bus.inta_n <= 1'b0;
            cnt        <= STROBE_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        INTA2: begin
          if (cnt == '0) begin
            state         <= IDONE;
            bus.inta_n    <= 1'b1;
            bus.vec_valid <= 1'b1;
            bus.vec_data  <= bus.d_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed plus randomized bench for pic_host_bus_master against a cycle-timeline model.
module tb_pic_host_bus_master;

  localparam int S = 2;
  localparam int G = 2;
  localparam int L = 2 * S + G + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] exp_vec = 8'h00;

  pic_host_bus_master_if bus ();

  pic_host_bus_master #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic ready_exp);
    chkb({tag, "_busy"}, bus.busy, 1'b0);
    chkb({tag, "_cs_n"}, bus.cs_n, 1'b1);
    chkb({tag, "_rd_n"}, bus.rd_n, 1'b1);
    chkb({tag, "_wr_n"}, bus.wr_n, 1'b1);
    chkb({tag, "_inta_n"}, bus.inta_n, 1'b1);
    chkb({tag, "_d_oe"}, bus.d_oe, 1'b0);
    chkb({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chkb({tag, "_vec_valid"}, bus.vec_valid, 1'b0);
    chkb({tag, "_cmd_ready"}, bus.cmd_ready, ready_exp);
    chk8({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    chk8({tag, "_vec_data"}, bus.vec_data, exp_vec);
  endtask

  // Entered in an IDLE cycle; leaves in the IDLE cycle after the bus cycle.
  task automatic do_cmd(input logic w, input logic a, input logic [7:0] wd, input logic [7:0] rd);
    bit strobe;
    bit act;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_a0    = a;
    bus.cmd_wdata = wd;
    chkb("cmd_accept_ready", bus.cmd_ready, 1'b1);
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_a0    = 1'($urandom);
    bus.cmd_wdata = 8'($urandom);
    for (int k = 1; k <= S + 3; k++) begin
      strobe = (k >= 2) && (k <= S + 1);
      act    = (k <= S + 2);
      chkb("cmd_busy", bus.busy, act);
      chkb("cmd_cs_n", bus.cs_n, !act);
      chkb("cmd_wr_n", bus.wr_n, !(w && strobe));
      chkb("cmd_rd_n", bus.rd_n, !(!w && strobe));
      chkb("cmd_d_oe", bus.d_oe, w && act);
      if (w && act) chk8("cmd_d_out", bus.d_out, wd);
      if (act) chkb("cmd_a0", bus.a0, a);
      chkb("cmd_inta_n", bus.inta_n, 1'b1);
      chkb("cmd_vec_valid", bus.vec_valid, 1'b0);
      if (!w && k == S + 2) exp_rdata = rd;
      chkb("cmd_rsp_valid", bus.rsp_valid, !w && (k == S + 2));
      chk8("cmd_rsp_rdata", bus.rsp_rdata, exp_rdata);
      chkb("cmd_ready_busy", bus.cmd_ready, !act);
      bus.d_in = (k == S + 1) ? rd : ~rd;
      if (k < S + 3) step();
    end
  endtask

  // Entered in an IDLE cycle with INT armed; leaves in the IDLE cycle after IDONE, pic_int still high.
  task automatic do_inta(input logic [7:0] v, input bit pend);
    bit low;
    bus.pic_int = 1'b1;
    step();
    chkb("int_sync1_ready", bus.cmd_ready, 1'b1);
    chkb("int_sync1_inta_n", bus.inta_n, 1'b1);
    step();
    chkb("int_prio_ready", bus.cmd_ready, 1'b0);
    chkb("int_sync2_inta_n", bus.inta_n, 1'b1);
    chkb("int_sync2_busy", bus.busy, 1'b0);
    if (pend) bus.cmd_valid = 1'b1;
    step();
    for (int k = 1; k <= L + 1; k++) begin
      low = ((k >= 1) && (k <= S)) || ((k >= S + G + 1) && (k <= 2 * S + G));
      chkb("inta_inta_n", bus.inta_n, !low);
      chkb("inta_busy", bus.busy, k <= L);
      chkb("inta_cs_n", bus.cs_n, 1'b1);
      chkb("inta_rd_n", bus.rd_n, 1'b1);
      chkb("inta_wr_n", bus.wr_n, 1'b1);
      chkb("inta_d_oe", bus.d_oe, 1'b0);
      chkb("inta_rsp_valid", bus.rsp_valid, 1'b0);
      if (k == L) exp_vec = v;
      chkb("inta_vec_valid", bus.vec_valid, k == L);
      chk8("inta_vec_data", bus.vec_data, exp_vec);
      chkb("inta_cmd_ready", bus.cmd_ready, k == L + 1);
      bus.d_in = (k == 2 * S + G) ? v : ~v;
      if (k < L + 1) step();
    end
  endtask

  task automatic drop_int();
    bus.pic_int = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("int_release", 1'b1);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_a0    = 1'b0;
    bus.cmd_wdata = 8'h00;
    bus.int_en    = 1'b1;
    bus.d_in      = 8'h00;
    bus.pic_int   = 1'b0;

    #12;
    check_quiet("reset", 1'b0);
    chkb("reset_a0", bus.a0, 1'b0);
    chk8("reset_d_out", bus.d_out, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    check_quiet("post_reset", 1'b1);

    do_cmd(1'b1, 1'b0, 8'h13, 8'h00);
    do_cmd(1'b0, 1'b1, 8'h00, 8'hA5);

    do_inta(8'h48, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_quiet("int_held", 1'b1);
    end
    drop_int();
    do_inta(8'h9C, 1'b0);
    drop_int();

    bus.int_en  = 1'b0;
    bus.pic_int = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_quiet("int_disabled", 1'b1);
    end
    drop_int();
    bus.int_en = 1'b1;

    bus.cmd_write = 1'b0;
    bus.cmd_a0    = 1'b1;
    bus.cmd_wdata = 8'h00;
    do_inta(8'h77, 1'b1);
    do_cmd(1'b0, 1'b1, 8'h00, 8'h3E);
    drop_int();

    for (int n = 0; n < 24; n++) begin
      int kind;
      int idle;
      kind = int'($urandom_range(0, 4));
      if (kind == 4) begin
        do_inta(8'($urandom), 1'b0);
        drop_int();
      end else begin
        do_cmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      end
      idle = int'($urandom_range(0, 2));
      for (int i = 0; i < idle; i++) begin
        step();
        check_quiet("rand_idle", 1'b1);
      end
    end

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_a0    = 1'b1;
    bus.cmd_wdata = 8'hC3;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    chkb("rst_pre_wr_n", bus.wr_n, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chkb("rst_async_wr_n", bus.wr_n, 1'b1);
    chkb("rst_async_cs_n", bus.cs_n, 1'b1);
    chkb("rst_async_d_oe", bus.d_oe, 1'b0);
    chkb("rst_async_ready", bus.cmd_ready, 1'b0);
    exp_rdata = 8'h00;
    exp_vec   = 8'h00;
    step();
    rst_n = 1'b1;
    #1;
    check_quiet("rst_release", 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("rst_after", 1'b1);
    end
    do_cmd(1'b0, 1'b0, 8'h00, 8'h5B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
